// File: rtl/elevator_call_scheduler.sv
// elevator_call_scheduler: sticky call capture, SCAN target selection and a watchdog-guarded move handshake for a 3-floor car
module elevator_call_scheduler #(
  parameter int SERVE_TIMEOUT = 64,
  parameter int TMR_W = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ground_flr_up_btn,
  input  logic       first_flr_up_btn,
  input  logic       first_flr_dwn_btn,
  input  logic       second_flr_dwn_btn,
  input  logic       go_to_ground_flr,
  input  logic       go_to_first_flr,
  input  logic       go_to_second_flr,
  input  logic [1:0] car_flr,
  output logic       cmd_valid,
  output logic [1:0] cmd_flr,
  input  logic       cmd_ready,
  input  logic       car_done,
  output logic [6:0] pending,
  output logic       dir_up,
  output logic       idle,
  output logic       fault
);
  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, SERVE, CLEAR} state_t;
  state_t state_q, state_d;
  logic [6:0] btn, prev_q, pending_q, pending_d, clr, hu_m, hd_m, car_m;
  logic [2:0] r;
  logic [1:0] flr_q, flr_d, up_f, dn_f;
  logic dir_q, dir_d, fault_q, fault_d, up_hit, dn_hit, beyond;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  assign btn = {go_to_second_flr, go_to_first_flr, go_to_ground_flr, second_flr_dwn_btn,
                first_flr_dwn_btn, first_flr_up_btn, ground_flr_up_btn};
  assign r = {pending_q[3] | pending_q[6], pending_q[1] | pending_q[2] | pending_q[5], pending_q[0] | pending_q[4]};
  assign hu_m = flr_q == 2'd0 ? 7'b0000001 : flr_q == 2'd1 ? 7'b0000010 : 7'b0;
  assign hd_m = flr_q == 2'd1 ? 7'b0000100 : flr_q == 2'd2 ? 7'b0001000 : 7'b0;
  assign car_m = 7'b0010000 << flr_q;
  // Nearest request above/below the car, and whether anything lies past the served floor
  always_comb begin
    up_hit = 1'b0;
    dn_hit = 1'b0;
    up_f = 2'd0;
    dn_f = 2'd0;
    beyond = 1'b0;
    for (int f = 2; f >= 0; f--)
      if (r[f] && f > int'(car_flr)) begin
        up_hit = 1'b1;
        up_f = 2'(f);
      end
    for (int f = 0; f < 3; f++) begin
      if (r[f] && f < int'(car_flr)) begin
        dn_hit = 1'b1;
        dn_f = 2'(f);
      end
      if (r[f] && (dir_q ? f > int'(flr_q) : f < int'(flr_q))) beyond = 1'b1;
    end
  end
  always_comb begin
    state_d = state_q;
    flr_d = flr_q;
    dir_d = dir_q;
    fault_d = fault_q;
    tmr_d = tmr_q;
    clr = 7'b0;
    case (state_q)
      IDLE: if (|pending_q) state_d = SELECT;
      SELECT:
        if (car_flr != 2'd3) begin
          state_d = ISSUE;
          if (dir_q ? up_hit : dn_hit) flr_d = dir_q ? up_f : dn_f;
          else if (dir_q ? dn_hit : up_hit) begin
            dir_d = !dir_q;
            flr_d = dir_q ? dn_f : up_f;
          end else if (r[car_flr]) flr_d = car_flr;
          else state_d = IDLE;
        end
      ISSUE:
        if (cmd_ready) begin
          state_d = SERVE;
          tmr_d = '0;
        end
      SERVE:
        if (car_done) state_d = CLEAR;
        else if (tmr_q == TMR_W'(SERVE_TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = ISSUE;
        end else tmr_d = tmr_q + TMR_W'(1);
      CLEAR: begin
        clr = car_m | (dir_q ? hu_m : hd_m) | (beyond ? 7'b0 : (dir_q ? hd_m : hu_m));
        dir_d = beyond ? dir_q : !dir_q;
        state_d = SELECT;
      end
      default: state_d = IDLE;
    endcase
    pending_d = (pending_q & ~clr) | (btn & ~prev_q);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      prev_q <= '0;
      pending_q <= '0;
      flr_q <= '0;
      dir_q <= 1'b1;
      fault_q <= 1'b0;
      tmr_q <= '0;
    end else begin
      state_q <= state_d;
      prev_q <= btn;
      pending_q <= pending_d;
      flr_q <= flr_d;
      dir_q <= dir_d;
      fault_q <= fault_d;
      tmr_q <= tmr_d;
    end
  end
  assign cmd_valid = state_q == ISSUE;
  assign cmd_flr = flr_q;
  assign pending = pending_q;
  assign dir_up = dir_q;
  assign idle = state_q == IDLE;
  assign fault = fault_q;
endmodule

// File: doc/elevator_call_scheduler.md
Name: elevator_call_scheduler

Overview:
- Request scheduler that sits in front of the three-floor Elevater car.
- Latches hall-call and car-call buttons into sticky pending bits and selects the next target floor using a direction-preserving (SCAN) policy.
- Issues one move command at a time to the car over a valid/ready handshake, then clears served calls when the car reports the door cycle complete.
- Adds a serve watchdog that flags a stalled car and re-issues the command.

Parameters:
SERVE_TIMEOUT, 64, maximum cycles in SERVE waiting for car_done before a fault; must be ≥2.
TMR_W, 7, width of the watchdog counter; must satisfy 2^TMR_W > SERVE_TIMEOUT.

Ports:
clk  in  1  system clock; all logic on its rising edge
rst  in  1  synchronous, active-high reset
ground_flr_up_btn  in  1  hall up call, floor 0
first_flr_up_btn  in  1  hall up call, floor 1
first_flr_dwn_btn  in  1  hall down call, floor 1
second_flr_dwn_btn  in  1  hall down call, floor 2
go_to_ground_flr  in  1  car call, floor 0
go_to_first_flr  in  1  car call, floor 1
go_to_second_flr  in  1  car call, floor 2
car_flr  in  2  car's current floor; 3 is invalid
cmd_valid  out  1  move command offered to the car
cmd_flr  out  2  target floor of the command
cmd_ready  in  1  car accepts the command
car_done  in  1  one-cycle pulse: car at cmd_flr, door cycle finished
pending  out  7  pending calls, bit order = button ports as listed above (bit0 = ground_flr_up_btn … bit6 = go_to_second_flr)
dir_up  out  1  scan direction: 1 = up, 0 = down
idle  out  1  FSM in IDLE
fault  out  1  sticky watchdog flag

Behaviour:
- Reset: clock and reset are a single clk; rst is synchronous and active-high.
  - While rst is sampled high: pending=0, dir_up=1, cmd_valid=0, cmd_flr=0, idle=1, fault=0, watchdog=0, button-history regs=0, state=IDLE.
  - Reset asserted mid-operation takes effect at the next edge: any offered command is withdrawn and all pending calls are dropped.
- Button capture:
  - A call registers on a rising edge (btn & ~prev).
  - The pending bit is set at the same edge the button is first sampled high.
  - A button held high across reset release registers one call.
  - A held button never re-registers.
- Floor request: R[f] = car call f | any hall call at f.
- FSM states: IDLE, SELECT, ISSUE, SERVE, CLEAR.
  - IDLE: go to SELECT when pending != 0.
  - SELECT (1 cycle):
    - If car_flr == 3, stay in SELECT.
    - If dir_up: target = lowest f > car_flr with R[f]. If none, set dir_up=0 and target = highest f < car_flr with R[f]. If none, target = car_flr when R[car_flr] is set.
    - If dir_up=0: the mirror of the above.
    - If there is no target, go to IDLE. Otherwise latch cmd_flr and go to ISSUE.
  - ISSUE:
    - cmd_valid=1; cmd_flr is held stable until cmd_ready is sampled high.
    - The transfer occurs on the cycle where valid & ready; the next state is SERVE, with cmd_valid=0 and the watchdog cleared.
  - SERVE:
    - car_done → CLEAR.
    - The watchdog increments each cycle. On reaching SERVE_TIMEOUT-1 without car_done: fault=1 and go to ISSUE, re-offering the same cmd_flr.
  - CLEAR (1 cycle):
    - Clear the car call at cmd_flr.
    - Clear the hall call at cmd_flr matching dir_up.
    - If no R[f] remains beyond cmd_flr in the current direction, also clear the opposite hall call at cmd_flr and invert dir_up.
    - Floor 0 and floor 2 each have only one hall call, so they always clear fully.
    - Next state: SELECT.
- Simultaneous events:
  - A new rising edge on a bit being cleared in CLEAR wins: the bit stays set and is served again.
  - car_done outside SERVE is ignored.
  - cmd_ready outside ISSUE is ignored.
- Latency: button first sampled high at edge k → pending at k, SELECT at k+1, cmd_valid=1 after edge k+2.
- fault is cleared only by rst.
- idle is decoded from the state register.

Test Plan:
1. Reset: rst=1 for 2 cycles with some buttons high → pending=0, cmd_valid=0, dir_up=1, fault=0, idle=1; after release the held buttons register once.
2. Handshake: car_flr=0, pulse second_flr_dwn_btn at edge k → cmd_valid=1 and cmd_flr=2 after edge k+2; hold cmd_ready=0 for 5 cycles → cmd_flr stays 2; assert ready → cmd_valid=0; pulse car_done → pending[3]=0, dir_up=0, idle=1 two cycles later.
3. SCAN order: car_flr=1, dir_up=1, press go_to_ground_flr and go_to_second_flr in the same cycle → first cmd_flr=2, then after car_done cmd_flr=0 with dir_up=0.
4. Floor-1 direction split: car_flr=0, first_flr_up_btn, first_flr_dwn_btn and go_to_second_flr pending → serve floor 1 clears only bit1; after floor 2 is served, dir_up=0 and floor 1 is served again, clearing bit2.
5. Clear/set collision: re-press go_to_first_flr in the CLEAR cycle for floor 1 → pending[5] remains 1 and a second command with cmd_flr=1 follows.
6. Watchdog and reset: no car_done for SERVE_TIMEOUT cycles → fault=1 and cmd_valid re-asserts with the same cmd_flr; then rst=1 for 1 cycle mid-ISSUE → cmd_valid=0, pending=0, fault=0.
